// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - parametrised UART receiver with majority voting and a valid/ready holding register
// Frames are sampled 3x around mid-bit and then delivered through a single-entry output register.
module uart_rx_ctrl #(
  parameter int DIVISOR    = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 RSTn,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(DIVISOR);
  localparam int IW = $clog2(DATA_BITS);
  localparam int H  = DIVISOR / 2;

  localparam logic [CW-1:0] C_PRE  = CW'(H - 1);
  localparam logic [CW-1:0] C_MID  = CW'(H);
  localparam logic [CW-1:0] C_DEC  = CW'(H + 1);
  localparam logic [CW-1:0] C_LAST = CW'(DIVISOR - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rxs;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic                 stop_idx;
  logic                 s0;
  logic                 s1;
  logic [DATA_BITS-1:0] data_sr;
  logic                 perr;
  logic                 ferr;

  logic maj;
  logic at_dec;
  logic at_last;
  logic frame_done;
  logic accept;
  logic can_load;

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RX;
      rxs     <= rx_meta;
    end
  end

  assign maj        = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign at_dec     = (cnt == C_DEC);
  assign at_last    = (cnt == C_LAST);
  assign frame_done = (state == STOP) && at_dec && (stop_idx == STOP_LAST);

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state    <= IDLE;
      busy     <= 1'b0;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      s0       <= 1'b1;
      s1       <= 1'b1;
      data_sr  <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      if (cnt == C_PRE) s0 <= rxs;
      if (cnt == C_MID) s1 <= rxs;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxs) begin
            state    <= START;
            busy     <= 1'b1;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
          end
        end

        START: begin
          cnt <= at_last ? '0 : cnt + 1'b1;
          // A start bit that votes high was noise; drop back without side effects.
          if (at_dec && maj) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (at_last) begin
            state <= DATA;
          end
        end

        DATA: begin
          cnt <= at_last ? '0 : cnt + 1'b1;
          if (at_dec) data_sr <= {maj, data_sr[DATA_BITS-1:1]};
          if (at_last) begin
            if (bit_idx == IDX_LAST) state <= (PARITY_EN != 0) ? PARITY : STOP;
            else bit_idx <= bit_idx + 1'b1;
          end
        end

        PARITY: begin
          cnt <= at_last ? '0 : cnt + 1'b1;
          if (at_dec) perr <= (^data_sr) ^ maj ^ PAR_ODD;
          if (at_last) state <= STOP;
        end

        STOP: begin
          cnt <= at_last ? '0 : cnt + 1'b1;
          if (at_last) stop_idx <= stop_idx + 1'b1;
          if (at_dec && !maj) ferr <= 1'b1;
          // Leaving at mid final stop bit leaves half a bit to resync on the next start edge.
          if (frame_done) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign accept   = data_valid && data_ready;
  assign can_load = !data_valid || data_ready;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      data_out     <= '0;
      data_valid   <= 1'b0;
      frame_error  <= 1'b0;
      parity_error <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (accept) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
      if (frame_done) begin
        if (can_load) begin
          data_out     <= data_sr;
          data_valid   <= 1'b1;
          frame_error  <= ferr | ~maj;
          parity_error <= perr;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule
